// File: rtl/sn74ls347_scan_ctrl.sv
// sn74ls347_scan_ctrl
//   Drives one shared sn74ls347 BCD-to-7-segment decoder across DIGITS
//   common-anode digits. Digits are scanned most significant first. Each
//   digit slot is a 1-cycle blank gap followed by PRESCALE lit cycles.
//   Leading-zero suppression is done here because the decoder's ripple-blank
//   chain cannot ripple across a single shared part.
//
// Ports
//   clk         system clock (rising edge)
//   clr_n       synchronous active-low reset
//   bcd_in      new display value, nibble i = digit i (digit 0 = LSD)
//   load        capture bcd_in into the pending register
//   blank_lz    enable leading-zero suppression (sampled per slot)
//   lamp_test   lamp test on all digits
//   dcba        BCD to decoder {d,c,b,a}
//   lt_n        decoder lamp-test input
//   rbi_n       decoder ripple-blank input
//   bi_n        decoder BI/RBO drive, 0 = blank
//   digit_en_n  active-low digit strobes, at most one low
//   frame_sync  one-cycle pulse at the start of each frame
//
// All outputs are registered. They present the decode of the scan state one
// cycle after that state is held.
module sn74ls347_scan_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 4
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  load,
    input  logic                  blank_lz,
    input  logic                  lamp_test,
    output logic [3:0]            dcba,
    output logic                  lt_n,
    output logic                  rbi_n,
    output logic                  bi_n,
    output logic [DIGITS-1:0]     digit_en_n,
    output logic                  frame_sync
);

    localparam int IW = $clog2(DIGITS);
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(PRESCALE - 1);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t              state, state_nx;
    logic [IW-1:0]       idx, idx_nx;
    logic [CW-1:0]       cnt, cnt_nx;
    logic [4*DIGITS-1:0] pending, active, act_cur;
    logic                lz_run, lz_nx;
    logic                blz_q, lt_q;
    logic                frame_entry, slot_end, suppress;
    logic [3:0]          nib;

    logic [3:0]          dcba_nx;
    logic                rbi_nx, bi_nx, fs_nx;
    logic [DIGITS-1:0]   en_nx;

    always_comb begin
        frame_entry = (state == BLANK) && (idx == LAST_IDX);
        // On frame entry the active register is being reloaded this cycle;
        // decode from the incoming value so the blank gap shows frame data.
        act_cur     = frame_entry ? (load ? bcd_in : pending) : active;
        nib         = act_cur[{idx, 2'b00} +: 4];
        slot_end    = (state == SHOW) && (cnt == LAST_CNT);
        // blank_lz / lamp_test are latched at the slot start so a change only
        // alters suppression from the next slot; a live lamp_test still
        // disables suppression immediately.
        suppress    = blz_q & ~lt_q & ~lamp_test & lz_run
                      & (nib == 4'd0) & (idx != '0);

        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt;
        lz_nx    = lz_run;
        case (state)
            BLANK: begin
                state_nx = SHOW;
                cnt_nx   = '0;
                if (frame_entry) lz_nx = 1'b1;
            end
            SHOW: begin
                if (slot_end) begin
                    state_nx = BLANK;
                    cnt_nx   = '0;
                    idx_nx   = (idx == '0) ? LAST_IDX : idx - 1'b1;
                    // invalid codes 10..15 count as nonzero too
                    if (nib != 4'd0) lz_nx = 1'b0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = BLANK;
        endcase

        dcba_nx = nib;
        bi_nx   = (state == SHOW);
        rbi_nx  = !((state == SHOW) && suppress);
        fs_nx   = frame_entry;
        en_nx   = '1;
        if (state == SHOW) en_nx[idx] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state      <= BLANK;
            idx        <= LAST_IDX;
            cnt        <= '0;
            pending    <= '0;
            active     <= '0;
            lz_run     <= 1'b1;
            blz_q      <= 1'b0;
            lt_q       <= 1'b0;
            dcba       <= 4'd0;
            lt_n       <= 1'b1;
            rbi_n      <= 1'b1;
            bi_n       <= 1'b0;
            digit_en_n <= '1;
            frame_sync <= 1'b0;
        end else begin
            state      <= state_nx;
            idx        <= idx_nx;
            cnt        <= cnt_nx;
            lz_run     <= lz_nx;
            if (load)        pending <= bcd_in;
            if (frame_entry) active  <= act_cur;
            if (state == BLANK) begin
                blz_q <= blank_lz;
                lt_q  <= lamp_test;
            end
            dcba       <= dcba_nx;
            lt_n       <= ~lamp_test;
            rbi_n      <= rbi_nx;
            bi_n       <= bi_nx;
            digit_en_n <= en_nx;
            frame_sync <= fs_nx;
        end
    end

endmodule

// File: tb/tb_sn74ls347_scan_ctrl.sv
module tb_sn74ls347_scan_ctrl;

    logic        clk = 1'b0;
    logic        clr_n;
    logic [15:0] bcd_in;
    logic        load, blank_lz, lamp_test;
    logic [3:0]  dcba;
    logic        lt_n, rbi_n, bi_n, frame_sync;
    logic [3:0]  digit_en_n;

    int errors = 0;
    int checks = 0;

    sn74ls347_scan_ctrl #(.DIGITS(4), .PRESCALE(4)) dut (
        .clk(clk), .clr_n(clr_n), .bcd_in(bcd_in), .load(load),
        .blank_lz(blank_lz), .lamp_test(lamp_test), .dcba(dcba),
        .lt_n(lt_n), .rbi_n(rbi_n), .bi_n(bi_n),
        .digit_en_n(digit_en_n), .frame_sync(frame_sync)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " digit_en_n"}, 32'(digit_en_n), 32'hF);
        chk({tag, " bi_n"},       32'(bi_n),       32'h0);
        chk({tag, " dcba"},       32'(dcba),       32'h0);
        chk({tag, " frame_sync"}, 32'(frame_sync), 32'h0);
        chk({tag, " lt_n"},       32'(lt_n),       32'h1);
        chk({tag, " rbi_n"},      32'(rbi_n),      32'h1);
    endtask

    // Advance (bounded) to the negedge where the frame_sync output is high.
    task automatic wait_fs();
        for (int i = 0; i < 60; i++) begin
            if (frame_sync === 1'b1) break;
            @(negedge clk);
        end
        chk("frame_sync seen", 32'(frame_sync), 32'h1);
    endtask

    // Check one whole frame starting at the frame_sync negedge; ends on the
    // next frame's frame_sync negedge (20 cycles later).
    // rbi_exp[d] is the expected rbi_n during digit d's lit slot.
    task automatic check_frame(input string tag, input logic [15:0] exp,
                               input logic [3:0] rbi_exp, input logic lt_exp,
                               input int ld_dig, input logic [15:0] ld_val);
        logic [3:0] en_exp;
        wait_fs();
        for (int d = 3; d >= 0; d--) begin
            chk($sformatf("%s d%0d blank bi_n", tag, d), 32'(bi_n), 32'h0);
            chk($sformatf("%s d%0d blank en", tag, d), 32'(digit_en_n), 32'hF);
            chk($sformatf("%s d%0d blank fs", tag, d), 32'(frame_sync), (d == 3) ? 32'h1 : 32'h0);
            en_exp = 4'hF;
            en_exp[d] = 1'b0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (c == 0) begin
                    chk($sformatf("%s d%0d en", tag, d),    32'(digit_en_n), 32'(en_exp));
                    chk($sformatf("%s d%0d bi_n", tag, d),  32'(bi_n),       32'h1);
                    chk($sformatf("%s d%0d dcba", tag, d),  32'(dcba),       32'(exp[4*d +: 4]));
                    chk($sformatf("%s d%0d rbi_n", tag, d), 32'(rbi_n),      32'(rbi_exp[d]));
                    chk($sformatf("%s d%0d lt_n", tag, d),  32'(lt_n),       32'(lt_exp));
                    if (ld_dig == d) begin
                        bcd_in = ld_val;
                        load   = 1'b1;
                    end
                end else begin
                    load = 1'b0;
                end
                if (c == 3)
                    chk($sformatf("%s d%0d en last", tag, d), 32'(digit_en_n), 32'(en_exp));
            end
            @(negedge clk);
        end
        chk({tag, " period fs"}, 32'(frame_sync), 32'h1);
    endtask

    task automatic do_load(input logic [15:0] v);
        bcd_in = v;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    initial begin
        clr_n = 1'b0; bcd_in = '0; load = 1'b0; blank_lz = 1'b0; lamp_test = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        clr_n = 1'b1;
        @(negedge clk);
        chk("post-reset fs", 32'(frame_sync), 32'h1);
        chk("post-reset blank en", 32'(digit_en_n), 32'hF);
        @(negedge clk);
        chk("post-reset d3 en", 32'(digit_en_n), 32'h7);

        // basic scan
        do_load(16'h1234);
        check_frame("basic", 16'h1234, 4'b1111, 1'b1, -1, 16'h0);
        // deferred load during digit 2 slot
        check_frame("defer_old", 16'h1234, 4'b1111, 1'b1, 2, 16'h5678);
        check_frame("defer_new", 16'h5678, 4'b1111, 1'b1, -1, 16'h0);

        // reset mid-SHOW (two cycles), clears pending/active too
        wait_fs();
        repeat (2) @(negedge clk);
        clr_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midreset");
        @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);
        chk("midreset fs", 32'(frame_sync), 32'h1);
        @(negedge clk);
        chk("midreset d3 en", 32'(digit_en_n), 32'h7);
        chk("midreset d3 dcba", 32'(dcba), 32'h0);

        // leading-zero suppression
        blank_lz = 1'b1;
        do_load(16'h0040);
        check_frame("lz0040", 16'h0040, 4'b0011, 1'b1, -1, 16'h0);
        do_load(16'h0000);
        check_frame("lz0000", 16'h0000, 4'b0001, 1'b1, -1, 16'h0);
        do_load(16'h00A0);
        check_frame("lz00A0", 16'h00A0, 4'b0011, 1'b1, -1, 16'h0);

        // lamp test
        do_load(16'h0000);
        lamp_test = 1'b1;
        check_frame("lamp", 16'h0000, 4'b1111, 1'b0, -1, 16'h0);
        // release mid-slot: suppression returns from the next slot
        @(negedge clk);
        chk("lamp rel d3 rbi_n", 32'(rbi_n), 32'h1);
        lamp_test = 1'b0;
        @(negedge clk);
        chk("lamp rel lt_n", 32'(lt_n), 32'h1);
        chk("lamp rel same slot rbi_n", 32'(rbi_n), 32'h1);
        repeat (4) @(negedge clk);
        chk("lamp rel d2 en", 32'(digit_en_n), 32'hB);
        chk("lamp rel d2 rbi_n", 32'(rbi_n), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
